// File: rtl/pipeline_ctl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctl
// Brief    : Stall/flush controller for the five-stage rv32i pipeline.
//            Generates latch load enables, valid-from-control bits and PC
//            update controls, drops stale fetch responses after a redirect
//            and keeps saturating stall/flush performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_ctl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,             // asynchronous, active-low
    input  logic             imem_resp,
    input  logic             mem_req,
    input  logic             dmem_resp,
    input  logic             id_valid,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic             br_taken,
    output logic             pc_load,
    output logic             pc_sel_redirect,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             vctl_if_id,
    output logic             vctl_id_ex,
    output logic             vctl_ex_mem,
    output logic             vctl_mem_wb,
    output logic             discarding,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_DISCARD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_mem_stall;
    logic w_lu_haz;
    logic w_redir;
    logic w_fetch_wait;
    logic w_stall_evt;
    logic w_flush_evt;

    // Hazard terms
    assign w_mem_stall  = mem_req & ~dmem_resp;
    assign w_lu_haz     = ex_valid & ex_is_load & (ex_rd != 5'd0) & id_valid &
                          ((id_use_rs1 & (id_rs1 == ex_rd)) |
                           (id_use_rs2 & (id_rs2 == ex_rd)));
    assign w_redir      = ex_valid & br_taken;
    assign w_fetch_wait = ~imem_resp;

    // A redirect held off by a memory stall is only counted when it is taken
    assign w_stall_evt  = w_mem_stall | w_lu_haz | w_fetch_wait | (r_state == ST_DISCARD);
    assign w_flush_evt  = w_redir & ~w_mem_stall;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control outputs by priority: mem_stall > redir > lu_haz > discard/fetch_wait > normal
    always_comb begin
        w_state_next    = r_state;
        pc_load         = 1'b0;
        pc_sel_redirect = 1'b0;
        load_if_id      = 1'b0;
        load_id_ex      = 1'b0;
        load_ex_mem     = 1'b0;
        load_mem_wb     = 1'b0;
        vctl_if_id      = 1'b1;
        vctl_id_ex      = 1'b1;
        vctl_ex_mem     = 1'b1;
        vctl_mem_wb     = 1'b1;
        discarding      = (r_state == ST_DISCARD);

        if (w_mem_stall) begin
            // Everything frozen; a stale fetch response can still retire the discard
            if ((r_state == ST_DISCARD) && imem_resp) begin
                w_state_next = ST_RUN;
            end
        end else if (w_redir) begin
            pc_load         = 1'b1;
            pc_sel_redirect = 1'b1;
            load_if_id      = 1'b1;
            load_id_ex      = 1'b1;
            load_ex_mem     = 1'b1;
            load_mem_wb     = 1'b1;
            vctl_if_id      = 1'b0;
            vctl_id_ex      = 1'b0;
            // An outstanding fetch (or one already being discarded) is for the wrong path
            if ((r_state == ST_DISCARD) || !imem_resp) begin
                w_state_next = ST_DISCARD;
            end else begin
                w_state_next = ST_RUN;
            end
        end else if (w_lu_haz) begin
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            vctl_id_ex  = 1'b0;
            // The stale response is gone once it arrives, even while IF/ID holds
            if ((r_state == ST_DISCARD) && imem_resp) begin
                w_state_next = ST_RUN;
            end
        end else if ((r_state == ST_DISCARD) || w_fetch_wait) begin
            load_if_id  = 1'b1;
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            vctl_if_id  = 1'b0;
            if ((r_state == ST_DISCARD) && imem_resp) begin
                w_state_next = ST_RUN;
            end
        end else begin
            pc_load     = 1'b1;
            load_if_id  = 1'b1;
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
        end

        // While reset is asserted no latch or PC may move
        if (!rst) begin
            pc_load         = 1'b0;
            pc_sel_redirect = 1'b0;
            load_if_id      = 1'b0;
            load_id_ex      = 1'b0;
            load_ex_mem     = 1'b0;
            load_mem_wb     = 1'b0;
            vctl_if_id      = 1'b0;
            vctl_id_ex      = 1'b0;
            vctl_ex_mem     = 1'b0;
            vctl_mem_wb     = 1'b0;
            discarding      = 1'b0;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            end
            if (w_flush_evt && (r_flush_cnt != c_cnt_max)) begin
                r_flush_cnt <= r_flush_cnt + c_cnt_one;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_ctl
// Brief    : Directed self-checking bench for pipeline_ctl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctl;

    logic        clk;
    logic        rst;
    logic        imem_resp, mem_req, dmem_resp;
    logic        id_valid, id_use_rs1, id_use_rs2;
    logic [4:0]  id_rs1, id_rs2;
    logic        ex_valid, ex_is_load;
    logic [4:0]  ex_rd;
    logic        br_taken;
    logic        pc_load, pc_sel_redirect;
    logic        load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic        vctl_if_id, vctl_id_ex, vctl_ex_mem, vctl_mem_wb;
    logic        discarding;
    logic [31:0] stall_cnt, flush_cnt;

    int checks;
    int errors;

    // Control vector: {pc_load, pc_sel, ld_ifid, ld_idex, ld_exmem, ld_memwb,
    //                  v_ifid, v_idex, v_exmem, v_memwb, discarding}
    localparam logic [10:0] c_zero   = 11'b0_0_0000_0000_0;
    localparam logic [10:0] c_normal = 11'b1_0_1111_1111_0;
    localparam logic [10:0] c_luhaz  = 11'b0_0_0111_1011_0;
    localparam logic [10:0] c_mstall = 11'b0_0_0000_1111_0;
    localparam logic [10:0] c_redir  = 11'b1_1_1111_0011_0;
    localparam logic [10:0] c_fwait  = 11'b0_0_1111_0111_0;
    localparam logic [10:0] c_disc   = 11'b0_0_1111_0111_1;

    logic [10:0] ctl;
    assign ctl = {pc_load, pc_sel_redirect, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                  vctl_if_id, vctl_id_ex, vctl_ex_mem, vctl_mem_wb, discarding};

    pipeline_ctl #(.CNT_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_resp       (imem_resp),
        .mem_req         (mem_req),
        .dmem_resp       (dmem_resp),
        .id_valid        (id_valid),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .ex_valid        (ex_valid),
        .ex_is_load      (ex_is_load),
        .ex_rd           (ex_rd),
        .br_taken        (br_taken),
        .pc_load         (pc_load),
        .pc_sel_redirect (pc_sel_redirect),
        .load_if_id      (load_if_id),
        .load_id_ex      (load_id_ex),
        .load_ex_mem     (load_ex_mem),
        .load_mem_wb     (load_mem_wb),
        .vctl_if_id      (vctl_if_id),
        .vctl_id_ex      (vctl_id_ex),
        .vctl_ex_mem     (vctl_ex_mem),
        .vctl_mem_wb     (vctl_mem_wb),
        .discarding      (discarding),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_ctl(input string tag, input logic [10:0] exp);
        checks++;
        assert (ctl === exp) else begin
            errors++;
            $error("FAIL %s: ctl observed %b expected %b", tag, ctl, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge, leaving time to drive and sample
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        imem_resp = 1'b1; mem_req = 1'b0; dmem_resp = 1'b0;
        id_valid = 1'b1; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        id_rs1 = 5'd0; id_rs2 = 5'd0;
        ex_valid = 1'b1; ex_is_load = 1'b0; ex_rd = 5'd0; br_taken = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        idle();
        #3;
        chk_ctl("reset_ctl", c_zero);
        chk_cnt("reset_stall", stall_cnt, 32'd0);
        chk_cnt("reset_flush", flush_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Steady stream
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk_ctl("steady", c_normal);
        end
        tick();
        chk_cnt("steady_stall", stall_cnt, 32'd0);

        // Load-use on rs2
        ex_is_load = 1'b1; ex_rd = 5'd5; id_use_rs2 = 1'b1; id_rs2 = 5'd5; #1;
        chk_ctl("luhaz_rs2", c_luhaz);
        tick();
        idle(); #1;
        chk_cnt("luhaz_stall", stall_cnt, 32'd1);
        chk_ctl("luhaz_after", c_normal);

        // Same pattern with x0 destination: no hazard
        ex_is_load = 1'b1; ex_rd = 5'd0; id_use_rs2 = 1'b1; id_rs2 = 5'd0; #1;
        chk_ctl("luhaz_x0", c_normal);
        tick();
        chk_cnt("luhaz_x0_stall", stall_cnt, 32'd1);

        // Load-use on rs1
        idle(); ex_is_load = 1'b1; ex_rd = 5'd7; id_use_rs1 = 1'b1; id_rs1 = 5'd7; #1;
        chk_ctl("luhaz_rs1", c_luhaz);
        tick();
        chk_cnt("luhaz_rs1_stall", stall_cnt, 32'd2);

        // Fetch wait in RUN
        idle(); imem_resp = 1'b0; #1;
        chk_ctl("fetch_wait", c_fwait);
        tick();
        chk_cnt("fwait_stall", stall_cnt, 32'd3);

        // Memory stall for two cycles, response on the third
        idle(); mem_req = 1'b1; #1;
        chk_ctl("mstall_1", c_mstall);
        tick(); #1;
        chk_ctl("mstall_2", c_mstall);
        tick();
        dmem_resp = 1'b1; #1;
        chk_ctl("mstall_resp", c_normal);
        tick();
        chk_cnt("mstall_cnt", stall_cnt, 32'd5);

        // Redirect with fetch outstanding, stale response two cycles later
        idle(); br_taken = 1'b1; imem_resp = 1'b0; #1;
        chk_ctl("redir", c_redir);
        tick();
        br_taken = 1'b0; #1;
        chk_ctl("discard_1", c_disc);
        tick();
        imem_resp = 1'b1; #1;
        chk_ctl("discard_stale", c_disc);
        tick(); #1;
        chk_ctl("discard_done", c_normal);
        chk_cnt("redir_flush", flush_cnt, 32'd1);

        // Redirect held behind a memory stall
        idle(); br_taken = 1'b1; mem_req = 1'b1; #1;
        chk_ctl("redir_mstall_1", c_mstall);
        tick(); #1;
        chk_ctl("redir_mstall_2", c_mstall);
        tick();
        chk_cnt("redir_mstall_flush", flush_cnt, 32'd1);
        dmem_resp = 1'b1; #1;
        chk_ctl("redir_taken", c_redir);
        tick();
        idle(); #1;
        chk_ctl("redir_after", c_normal);
        chk_cnt("redir_once", flush_cnt, 32'd2);

        // Stall counter saturation
        force dut.r_stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_stall_cnt;
        mem_req = 1'b1;
        tick(); tick(); tick();
        chk_cnt("stall_sat", stall_cnt, 32'hFFFF_FFFF);

        // Asynchronous reset in the middle of DISCARD
        idle(); br_taken = 1'b1; imem_resp = 1'b0;
        tick();
        br_taken = 1'b0; #1;
        chk_ctl("pre_reset_disc", c_disc);
        rst = 1'b0; #1;
        chk_ctl("async_reset_ctl", c_zero);
        chk_cnt("async_reset_stall", stall_cnt, 32'd0);
        chk_cnt("async_reset_flush", flush_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b1; #1;
        chk_ctl("post_reset_run", c_fwait);
        imem_resp = 1'b1; #1;
        chk_ctl("post_reset_resp", c_normal);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_ctl.md
# pipeline_ctl

Central stall/flush controller for the five-stage rv32i pipeline. Each cycle it decides which inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) load and whether each loaded entry is valid. It also decides when the PC advances or takes a branch redirect. It tracks in-flight instruction fetches across redirects so that stale fetch responses are dropped, and it keeps saturating stall/flush performance counters.

## Interface
Parameters:
- `CNT_W`, 32, width of performance counters.

Ports:
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `imem_resp`  in  1  instruction fetch for the current request completes this cycle.
- `mem_req`  in  1  EX/MEM latch holds a valid load/store.
- `dmem_resp`  in  1  data access completes this cycle.
- `id_valid`, `id_use_rs1`, `id_use_rs2`  in  1 each  IF/ID entry is valid and reads rs1/rs2.
- `id_rs1`, `id_rs2`  in  5 each  IF/ID source registers.
- `ex_valid`, `ex_is_load`  in  1 each  ID/EX entry is valid and is a load.
- `ex_rd`  in  5  ID/EX destination register.
- `br_taken`  in  1  EX stage resolves a taken branch/jump; qualified by `ex_valid`.
- `pc_load`  out  1  PC register update enable.
- `pc_sel_redirect`  out  1  PC mux selects the EX target (else PC+4).
- `load_if_id`, `load_id_ex`, `load_ex_mem`, `load_mem_wb`  out  1 each  latch load enables.
- `vctl_if_id`, `vctl_id_ex`, `vctl_ex_mem`, `vctl_mem_wb`  out  1 each  valid-from-control for each latch.
- `discarding`  out  1  high in DISCARD state.
- `stall_cnt`, `flush_cnt`  out  CNT_W each  performance counters.

## Operation
- Hazard terms (combinational):
  - `mem_stall = mem_req & ~dmem_resp`.
  - `lu_haz = ex_valid & ex_is_load & (ex_rd != 0) & id_valid & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd))`.
  - `redir = ex_valid & br_taken`.
  - `fetch_wait = ~imem_resp`.
- Priority: mem_stall > redir > lu_haz > fetch_wait/discard > normal.
- FSM states: RUN, DISCARD.
- mem_stall (any state):
  - All `load_*` = 0 and `pc_load` = 0.
  - FSM holds, except that in DISCARD an `imem_resp` is still consumed (DISCARD→RUN).
- redir:
  - `pc_load` = 1, `pc_sel_redirect` = 1.
  - All four latches load.
  - `vctl_if_id` = 0, `vctl_id_ex` = 0; other vctl = 1.
  - If `imem_resp` = 0 this cycle, next state is DISCARD; otherwise RUN.
  - `flush_cnt` += 1.
- lu_haz:
  - `pc_load` = 0, `load_if_id` = 0.
  - `load_id_ex` = 1 with `vctl_id_ex` = 0 (bubble).
  - EX/MEM and MEM/WB load with vctl 1.
- RUN with fetch_wait:
  - `pc_load` = 0.
  - `load_if_id` = 1 with `vctl_if_id` = 0.
  - Downstream latches load with vctl 1.
- DISCARD (no higher-priority event):
  - `pc_load` = 0.
  - IF/ID loads with vctl 0, whether or not `imem_resp` is asserted.
  - Downstream latches load normally.
  - `imem_resp` = 1 drops the stale instruction and moves the FSM to RUN. The next fetch uses the redirected PC.
- A redir while in DISCARD keeps the FSM in DISCARD.
- Normal operation: every `load_*` = 1, every vctl = 1, `pc_load` = 1, `pc_sel_redirect` = 0.
- `stall_cnt` += 1 in any cycle with mem_stall, lu_haz, fetch_wait, or DISCARD.
- Both counters saturate at all-ones and never wrap.
- Outputs whose latch is not loaded drive vctl = 1 (don't-care, fixed for determinism).

## Timing
- All control outputs are combinational from inputs and state. Latches and PC sample them on the same edge.
- A redirect is visible in PC one edge after `redir`. The two wrong-path slots become bubbles on that same edge.
- Load-use costs exactly one bubble cycle. The dependent instruction enters EX one cycle later.
- DISCARD lasts until the first `imem_resp` (minimum one cycle).
- Reset (`rst` low, asynchronous):
  - State is RUN and both counters are 0.
  - All `load_*`, `pc_load`, `pc_sel_redirect`, vctl, and `discarding` are forced 0 while reset is asserted.
- Reset asserted mid-DISCARD returns the FSM to RUN. The first `imem_resp` after reset is accepted.

## Test plan
- Steady stream with `imem_resp` = 1 and no hazards → all loads and vctl = 1 every cycle; `stall_cnt` stays 0.
- `ex_is_load`, `ex_rd` = 5, `id_rs2` = 5, `id_use_rs2` = 1 → one cycle with `pc_load` = 0, `load_if_id` = 0, `vctl_id_ex` = 0; `stall_cnt` = 1. Repeating with `ex_rd` = 0 → no stall.
- `mem_req` = 1 for 3 cycles, then `dmem_resp` on the 3rd → first two cycles all loads 0; third cycle resumes; `stall_cnt` = 2.
- `br_taken` with `imem_resp` = 0, then `imem_resp` 2 cycles later → redirect cycle flushes IF/ID and ID/EX; `discarding` high 2 cycles; stale response loads IF/ID with vctl 0; `flush_cnt` = 1.
- `br_taken` concurrent with mem_stall for 2 cycles → no PC update until `dmem_resp`, then redirect is taken exactly once.
- Counter preloaded to 0xFFFF_FFFE (force), 3 stall cycles → value holds at 0xFFFF_FFFF. Async `rst` low mid-DISCARD → outputs 0 immediately, FSM in RUN.
